router_fsm: RTL and testbench

- Single-port packet router control FSM.
- Configuration: the router is taken online by a config handshake that assigns its 12-bit node address.
- Packet path: each received packet is validated by a multi-cycle popcount checksum, acknowledged, routed through an address mask, then transmitted with confirm/retry handling.
- Keeps running good/failed packet counters. Sits between the link receive side and the downstream transmit port.

---
 rtl/router_fsm.sv | 168 ++++++++++++++++
 tb/tb_router_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// router_fsm: control FSM for a single-port packet router.
// A config handshake takes the router online and stores a 12-bit node
// address. Each received packet is checked with a popcount checksum spread
// over four cycles (one byte per cycle). A good packet is acknowledged,
// routed through an address mask and transmitted. Delivery then waits for a
// downstream confirmation, with one retry window before the packet is
// declared failed.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   config_in, receive, ack_in control inputs
//   header_in, address_in      expected popcount, destination address
//   data_in                    packet payload or config word
//   ready, bad_packet, ack_out, lookup, transmit  Moore state flags
//   address_out                last routed (masked) address
//   packets_ok, packets_fail   wrapping delivery counters
//   state                      current state encoding
module router_fsm #(
  parameter int          CNT_W          = 16,
  parameter logic [11:0] LOOKUP_MASK    = 12'h3FC,
  parameter int          CONFIRM_CYCLES = 4,
  parameter int          RETRY_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             config_in,
  input  logic             receive,
  input  logic             ack_in,
  input  logic [5:0]       header_in,
  input  logic [11:0]      address_in,
  input  logic [31:0]      data_in,
  output logic             ready,
  output logic             bad_packet,
  output logic             ack_out,
  output logic             lookup,
  output logic             transmit,
  output logic [11:0]      address_out,
  output logic [CNT_W-1:0] packets_ok,
  output logic [CNT_W-1:0] packets_fail,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_OFFLINE  = 4'd0,
    S_CONFIG   = 4'd1,
    S_READY    = 4'd2,
    S_CHECKSUM = 4'd3,
    S_ACK      = 4'd4,
    S_LOOKUP   = 4'd5,
    S_TRANSMIT = 4'd6,
    S_CONFIRM  = 4'd7,
    S_RETRY    = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  state_t      st;
  logic [11:0] node_addr;
  logic [5:0]  hdr_q;
  logic [11:0] addr_q;
  logic [31:0] data_q;
  logic [5:0]  computed_header;
  logic [1:0]  byte_idx;
  logic [11:0] address_store;
  logic [7:0]  timer;
  logic [3:0]  byte_pop;
  logic [5:0]  csum;

  // Popcount of the byte currently being folded into the checksum.
  always_comb begin
    byte_pop = '0;
    for (int i = 0; i < 8; i++)
      byte_pop = byte_pop + {3'b000, data_q[{byte_idx, 3'b000} + 5'(i)]};
  end

  assign csum = computed_header + {2'b00, byte_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= S_OFFLINE;
      node_addr       <= '0;
      hdr_q           <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      computed_header <= '0;
      byte_idx        <= '0;
      address_store   <= '0;
      address_out     <= '0;
      timer           <= '0;
      packets_ok      <= '0;
      packets_fail    <= '0;
    end else begin
      case (st)
        S_OFFLINE: if (config_in) st <= S_CONFIG;
        S_CONFIG: begin
          if (receive) begin
            // A zero address declines configuration.
            if (data_in[11:0] == 12'h000) st <= S_OFFLINE;
            else begin
              node_addr <= data_in[11:0];
              st        <= S_READY;
            end
          end
        end
        S_READY: begin
          if (config_in) st <= S_CONFIG;
          else if (receive) begin
            hdr_q           <= header_in;
            addr_q          <= address_in;
            data_q          <= data_in;
            computed_header <= '0;
            byte_idx        <= '0;
            st              <= S_CHECKSUM;
          end
        end
        S_CHECKSUM: begin
          computed_header <= csum;
          byte_idx        <= byte_idx + 2'd1;
          // Compare against the sum that includes the final byte.
          if (byte_idx == 2'd3) st <= (csum == hdr_q) ? S_ACK : S_ERROR;
        end
        S_ACK: begin
          address_store <= addr_q & LOOKUP_MASK;
          st            <= S_LOOKUP;
        end
        S_LOOKUP: begin
          // Publish the routed address so it is visible during TRANSMIT.
          address_out <= address_store;
          timer       <= '0;
          st          <= S_TRANSMIT;
        end
        S_TRANSMIT: begin
          timer <= '0;
          st    <= S_CONFIRM;
        end
        S_CONFIRM: begin
          if (ack_in) begin
            packets_ok <= packets_ok + 1'b1;
            st         <= S_READY;
          end else if (timer == 8'(CONFIRM_CYCLES - 1)) begin
            timer <= '0;
            st    <= S_RETRY;
          end else timer <= timer + 8'd1;
        end
        S_RETRY: begin
          if (ack_in) begin
            packets_ok <= packets_ok + 1'b1;
            st         <= S_READY;
          end else if (timer == 8'(RETRY_CYCLES - 1)) begin
            timer <= '0;
            st    <= S_ERROR;
          end else timer <= timer + 8'd1;
        end
        S_ERROR: begin
          packets_fail <= packets_fail + 1'b1;
          st           <= S_READY;
        end
        default: st <= S_OFFLINE;
      endcase
    end
  end

  assign state      = st;
  assign ready      = (st == S_READY);
  assign bad_packet = (st == S_ERROR);
  assign ack_out    = (st == S_ACK);
  assign lookup     = (st == S_LOOKUP);
  assign transmit   = (st == S_TRANSMIT) || (st == S_RETRY);

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed scenarios plus randomized packets checked
// against a packet-level model of the expected state trajectory.
module tb_router_fsm;
  logic        clk = 1'b0;
  logic        reset, config_in, receive, ack_in;
  logic [5:0]  header_in;
  logic [11:0] address_in;
  logic [31:0] data_in;
  logic        ready, bad_packet, ack_out, lookup, transmit;
  logic [11:0] address_out;
  logic [15:0] packets_ok, packets_fail;
  logic [3:0]  state;

  int errors = 0;
  int checks = 0;

  // Model state at packet granularity.
  logic [15:0] m_ok, m_fail;
  logic [11:0] m_addr;

  router_fsm dut (
    .clk(clk), .reset(reset), .config_in(config_in), .receive(receive),
    .ack_in(ack_in), .header_in(header_in), .address_in(address_in),
    .data_in(data_in), .ready(ready), .bad_packet(bad_packet),
    .ack_out(ack_out), .lookup(lookup), .transmit(transmit),
    .address_out(address_out), .packets_ok(packets_ok),
    .packets_fail(packets_fail), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; config_in = 1'b1; receive = 1'b1; ack_in = 1'b1;
    header_in = '0; address_in = '0; data_in = '0;
    repeat (10) tick();
    checks++;
    if (state !== 4'd0 || {ready, bad_packet, ack_out, lookup, transmit} !== 5'b0 ||
        packets_ok !== 16'd0 || packets_fail !== 16'd0 || address_out !== 12'd0) begin
      errors++;
      $display("FAIL reset: state=%0d flags=%b ok=%0d fail=%0d addr=%h, want all 0",
               state, {ready, bad_packet, ack_out, lookup, transmit},
               packets_ok, packets_fail, address_out);
    end
    reset = 1'b0; config_in = 1'b0; receive = 1'b0; ack_in = 1'b0;
    m_ok = '0; m_fail = '0; m_addr = '0;
    tick();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL idle_offline: state=%0d want 0", state);
    end
  endtask

  task automatic test_config();
    config_in = 1'b1; tick(); config_in = 1'b0;
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL enter_config: state=%0d want 1", state); end
    tick();
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL config_hold: state=%0d want 1", state); end
    receive = 1'b1; data_in = 32'h0; tick(); receive = 1'b0;
    checks++;
    if (state !== 4'd0 || ready !== 1'b0) begin
      errors++; $display("FAIL config_zero: state=%0d ready=%b want 0/0", state, ready);
    end
    config_in = 1'b1; tick(); config_in = 1'b0;
    receive = 1'b1; data_in = 32'h00000FFF; tick(); receive = 1'b0;
    checks++;
    if (state !== 4'd2 || ready !== 1'b1) begin
      errors++; $display("FAIL config_ok: state=%0d ready=%b want 2/1", state, ready);
    end
    // config_in outranks receive in READY.
    config_in = 1'b1; receive = 1'b1; tick(); config_in = 1'b0; receive = 1'b0;
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL config_priority: state=%0d want 1", state); end
    receive = 1'b1; data_in = 32'h00000005; tick(); receive = 1'b0;
    checks++;
    if (state !== 4'd2) begin errors++; $display("FAIL reconfig: state=%0d want 2", state); end
  endtask

  // mode 0: ack in CONFIRM cycle k; mode 1: ack in RETRY cycle k; mode 2: no ack.
  task automatic run_packet(input logic [31:0] d, input logic [5:0] h,
                            input logic [11:0] a, input int mode, input int k,
                            input bit noise);
    logic [3:0]  eq[$];
    bit          aq[$];
    logic [11:0] adq[$];
    logic [11:0] routed;
    logic [4:0]  fexp;
    routed = a & 12'h3FC;
    for (int i = 0; i < 4; i++) begin eq.push_back(4'd3); aq.push_back(1'b0); adq.push_back(m_addr); end
    if ($countones(d) != int'(h)) begin
      eq.push_back(4'd9); aq.push_back(1'b0); adq.push_back(m_addr);
    end else begin
      eq.push_back(4'd4); aq.push_back(1'b0); adq.push_back(m_addr);
      eq.push_back(4'd5); aq.push_back(1'b0); adq.push_back(m_addr);
      eq.push_back(4'd6); aq.push_back(1'b0); adq.push_back(routed);
      for (int i = 0; i < 4; i++) begin
        if (mode == 0 && i > k) break;
        eq.push_back(4'd7); aq.push_back(mode == 0 && i == k); adq.push_back(routed);
      end
      if (mode != 0)
        for (int i = 0; i < 4; i++) begin
          if (mode == 1 && i > k) break;
          eq.push_back(4'd8); aq.push_back(mode == 1 && i == k); adq.push_back(routed);
        end
      if (mode == 2) begin eq.push_back(4'd9); aq.push_back(1'b0); adq.push_back(routed); end
    end
    receive = 1'b1; data_in = d; header_in = h; address_in = a;
    tick();
    for (int i = 0; i < eq.size(); i++) begin
      fexp = {eq[i] == 4'd2, eq[i] == 4'd9, eq[i] == 4'd4, eq[i] == 4'd5,
              eq[i] == 4'd6 || eq[i] == 4'd8};
      checks++;
      if (state !== eq[i] || {ready, bad_packet, ack_out, lookup, transmit} !== fexp ||
          address_out !== adq[i]) begin
        errors++;
        $display("FAIL pkt_step%0d: state=%0d flags=%b addr=%h, want %0d/%b/%h",
                 i, state, {ready, bad_packet, ack_out, lookup, transmit}, address_out,
                 eq[i], fexp, adq[i]);
      end
      // Inputs other than ack_in in the wait states are don't-care here.
      receive   = noise ? 1'($urandom) : 1'b0;
      config_in = noise ? 1'($urandom) : 1'b0;
      data_in   = $urandom;
      ack_in    = (eq[i] == 4'd7 || eq[i] == 4'd8) ? aq[i] : (noise ? 1'($urandom) : 1'b0);
      tick();
    end
    receive = 1'b0; config_in = 1'b0; ack_in = 1'b0;
    if (eq[eq.size()-1] == 4'd9) m_fail++; else m_ok++;
    if (eq.size() > 5) m_addr = routed;
    checks++;
    if (state !== 4'd2 || ready !== 1'b1 || transmit !== 1'b0 || packets_ok !== m_ok ||
        packets_fail !== m_fail || address_out !== m_addr) begin
      errors++;
      $display("FAIL pkt_done: state=%0d ok=%0d fail=%0d addr=%h, want 2/%0d/%0d/%h",
               state, packets_ok, packets_fail, address_out, m_ok, m_fail, m_addr);
    end
  endtask

  task automatic test_directed();
    run_packet(32'h00000FFF, 6'd13, 12'hF0F, 0, 0, 1'b0);
    run_packet(32'hFFFFFFFF, 6'd32, 12'hF0F, 0, 0, 1'b0);
    run_packet(32'h55555555, 6'd16, 12'hFFF, 1, 0, 1'b0);
    run_packet(32'h00000000, 6'd0,  12'h000, 2, 0, 1'b0);
    run_packet(32'h80000001, 6'd2,  12'h003, 0, 3, 1'b0);
    run_packet(32'h12345678, 6'd13, 12'hABC, 1, 3, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [5:0]  h;
    for (int n = 0; n < 40; n++) begin
      d = $urandom;
      h = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($countones(d));
      run_packet(d, h, 12'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_decommission();
    config_in = 1'b1; tick(); config_in = 1'b0;
    receive = 1'b1; data_in = 32'hFFFFF000; tick(); receive = 1'b0;
    checks++;
    if (state !== 4'd0 || ready !== 1'b0 || packets_ok !== m_ok) begin
      errors++; $display("FAIL decommission: state=%0d ok=%0d want 0/%0d", state, packets_ok, m_ok);
    end
  endtask

  task automatic test_midop_reset();
    config_in = 1'b1; tick(); config_in = 1'b0;
    receive = 1'b1; data_in = 32'h1; tick();
    data_in = 32'hFFFFFFFF; header_in = 6'd32; address_in = 12'hFFF; tick(); receive = 1'b0;
    repeat (6) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (state !== 4'd0 || packets_ok !== 16'd0 || packets_fail !== 16'd0 || address_out !== 12'd0) begin
      errors++;
      $display("FAIL midop_reset: state=%0d ok=%0d fail=%0d addr=%h want 0/0/0/0",
               state, packets_ok, packets_fail, address_out);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_config();
    test_directed();
    test_random();
    test_decommission();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
